// File: rtl/jzjpcc_memory_stage_hs_if.sv
// Data-bus handshake between the memory stage (master) and a variable-latency backend (slave).
// Request is valid/ready; the response is a single valid strobe with no back-pressure.
interface jzjpcc_memory_stage_hs_if #(
  parameter int XLEN = 32
) ();
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [XLEN-3:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [3:0]      req_byteMask;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_byteMask,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_byteMask,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/jzjpcc_memory_stage_hs.sv
// Memory stage between execute and writeback: drives the handshaked data bus and aligns/extends data.
// Define JZJPCC_MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
module jzjpcc_memory_stage_hs #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ex_valid,
  input  logic                      ex_memRead,
  input  logic                      ex_memWrite,
  input  logic [XLEN-1:0]           ex_addr,
  input  logic [XLEN-1:0]           ex_wdata,
  input  logic [2:0]                ex_funct3,
  input  logic [XLEN-1:0]           ex_aluResult,
  input  logic [4:0]                ex_rdAddr,
  input  logic                      ex_rdWriteEnable,
  output logic                      stall,
  jzjpcc_memory_stage_hs_if.master  bus,
  output logic                      wb_valid,
  output logic [4:0]                wb_rdAddr,
  output logic                      wb_rdWriteEnable,
  output logic [XLEN-1:0]           wb_rdData,
  output logic                      bus_error,
  output logic                      misalign
);

  if (XLEN != 32) begin : gXlenCheck
    $error("jzjpcc_memory_stage_hs supports XLEN=32 only");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            write_q, write_d;
  logic [4:0]      rdAddr_q, rdAddr_d;
  logic            rdWe_q, rdWe_d;
  logic            wbValid_q, wbValid_d;
  logic [4:0]      wbRdAddr_q, wbRdAddr_d;
  logic            wbWe_q, wbWe_d;
  logic [XLEN-1:0] wbData_q, wbData_d;
  logic            busErr_q, busErr_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     wdCnt_q, wdCnt_d;

  logic            isMem;
  logic            misalignHit;
  logic            timeoutHit;
  logic [1:0]      laneOff;
  logic [7:0]      loadByte;
  logic [15:0]     loadHalf;
  logic [XLEN-1:0] loadData;

  assign isMem = ex_memRead | ex_memWrite;

`ifdef JZJPCC_MEM_MISALIGN_TRAP_EN
  assign misalignHit = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                       ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
`else
  assign misalignHit = 1'b0;
`endif

  assign timeoutHit = (TIMEOUT_CYCLES > 0) && (wdCnt_q == 32'(TIMEOUT_CYCLES - 1));

  // Lane selection ignores address bits finer than the access size.
  always_comb begin
    laneOff = 2'b00;
    case (funct3_q[1:0])
      2'b00:   laneOff = addr_q[1:0];
      2'b01:   laneOff = {addr_q[1], 1'b0};
      default: laneOff = 2'b00;
    endcase
  end

  always_comb begin
    loadByte = bus.rsp_rdata[{addr_q[1:0], 3'b000} +: 8];
    loadHalf = bus.rsp_rdata[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  loadData = {{(XLEN-8){loadByte[7]}}, loadByte};
      3'b100:  loadData = {{(XLEN-8){1'b0}}, loadByte};
      3'b001:  loadData = {{(XLEN-16){loadHalf[15]}}, loadHalf};
      3'b101:  loadData = {{(XLEN-16){1'b0}}, loadHalf};
      default: loadData = bus.rsp_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      wbValid_q  <= 1'b0;
      wbWe_q     <= 1'b0;
      busErr_q   <= 1'b0;
      misalign_q <= 1'b0;
      wdCnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      write_q    <= write_d;
      rdAddr_q   <= rdAddr_d;
      rdWe_q     <= rdWe_d;
      wbValid_q  <= wbValid_d;
      wbRdAddr_q <= wbRdAddr_d;
      wbWe_q     <= wbWe_d;
      wbData_q   <= wbData_d;
      busErr_q   <= busErr_d;
      misalign_q <= misalign_d;
      wdCnt_q    <= wdCnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    write_d    = write_q;
    rdAddr_d   = rdAddr_q;
    rdWe_d     = rdWe_q;
    wbValid_d  = 1'b0;
    wbRdAddr_d = wbRdAddr_q;
    wbWe_d     = wbWe_q;
    wbData_d   = wbData_q;
    busErr_d   = 1'b0;
    misalign_d = 1'b0;
    wdCnt_d    = '0;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!isMem) begin
            wbValid_d  = 1'b1;
            wbData_d   = ex_aluResult;
            wbRdAddr_d = ex_rdAddr;
            wbWe_d     = ex_rdWriteEnable;
          end else if (misalignHit) begin
            wbValid_d  = 1'b1;
            wbRdAddr_d = ex_rdAddr;
            wbWe_d     = 1'b0;
            misalign_d = 1'b1;
          end else begin
            addr_d   = ex_addr;
            wdata_d  = ex_wdata;
            funct3_d = ex_funct3;
            write_d  = ex_memWrite & ~ex_memRead;
            rdAddr_d = ex_rdAddr;
            rdWe_d   = ex_rdWriteEnable;
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        if (bus.req_ready) begin
          if (write_q) begin
            wbValid_d  = 1'b1;
            wbRdAddr_d = rdAddr_q;
            wbWe_d     = 1'b0;
            state_d    = IDLE;
          end else begin
            state_d = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        // A response in the same cycle the watchdog expires takes priority.
        if (bus.rsp_valid) begin
          wbValid_d  = 1'b1;
          wbRdAddr_d = rdAddr_q;
          wbWe_d     = rdWe_q;
          wbData_d   = loadData;
          state_d    = IDLE;
        end else if (timeoutHit) begin
          wbValid_d  = 1'b1;
          wbRdAddr_d = rdAddr_q;
          wbWe_d     = 1'b0;
          busErr_d   = 1'b1;
          state_d    = IDLE;
        end else begin
          wdCnt_d = wdCnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall            = (state_q != IDLE);
    bus.req_valid    = (state_q == REQ);
    bus.req_write    = write_q;
    bus.req_addr     = addr_q[XLEN-1:2];
    bus.req_wdata    = wdata_q << {laneOff, 3'b000};
    case (funct3_q[1:0])
      2'b00:   bus.req_byteMask = 4'b0001 << addr_q[1:0];
      2'b01:   bus.req_byteMask = 4'b0011 << {addr_q[1], 1'b0};
      default: bus.req_byteMask = 4'b1111;
    endcase
    wb_valid         = wbValid_q;
    wb_rdAddr        = wbRdAddr_q;
    wb_rdWriteEnable = wbWe_q;
    wb_rdData        = wbData_q;
    bus_error        = busErr_q;
    misalign         = misalign_q;
  end

endmodule

// File: tb/tb_jzjpcc_memory_stage_hs.sv
// Directed self-checking bench for jzjpcc_memory_stage_hs (watchdog set to 4 cycles).
// Build with JZJPCC_MEM_MISALIGN_TRAP_EN to exercise the misalignment trap path.
module tb_jzjpcc_memory_stage_hs;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid, ex_memRead, ex_memWrite;
  logic [31:0] ex_addr, ex_wdata, ex_aluResult;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rdAddr;
  logic        ex_rdWriteEnable;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rdAddr;
  logic        wb_rdWriteEnable;
  logic [31:0] wb_rdData;
  logic        bus_error, misalign;

  int total = 0;
  int bad   = 0;

  jzjpcc_memory_stage_hs_if #(.XLEN(32)) bus ();

  jzjpcc_memory_stage_hs #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_funct3(ex_funct3),
    .ex_aluResult(ex_aluResult), .ex_rdAddr(ex_rdAddr), .ex_rdWriteEnable(ex_rdWriteEnable),
    .stall(stall), .bus(bus),
    .wb_valid(wb_valid), .wb_rdAddr(wb_rdAddr), .wb_rdWriteEnable(wb_rdWriteEnable),
    .wb_rdData(wb_rdData), .bus_error(bus_error), .misalign(misalign)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [2:0] f3, input logic [31:0] alu,
                               input logic [4:0] rdA, input logic we);
    ex_valid = v; ex_memRead = rd; ex_memWrite = wr; ex_addr = a; ex_wdata = wd;
    ex_funct3 = f3; ex_aluResult = alu; ex_rdAddr = rdA; ex_rdWriteEnable = we;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 5'd0, 1'b0);
  endtask

  // Issues a load, handshakes immediately, responds rspDelay cycles after the handshake; returns in cycle R+1.
  task automatic doLoad(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata,
                        input int rspDelay, input logic [4:0] rdA);
    applyStimulus(1'b1, 1'b1, 1'b0, a, 32'h0, f3, 32'h0, rdA, 1'b1);
    tick();
    applyIdle();
    checkOutput("ld_req_valid", {31'd0, bus.req_valid}, 32'd1);
    checkOutput("ld_req_write", {31'd0, bus.req_write}, 32'd0);
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    for (int i = 1; i < rspDelay; i++) tick();
    bus.rsp_valid = 1'b1;
    bus.rsp_rdata = rdata;
    tick();
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 32'h0;
  endtask

  initial begin
    reset = 1'b1;
    applyIdle();
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 32'h0;
    tick(); tick();
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_req_valid", {31'd0, bus.req_valid}, 32'd0);
    checkOutput("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("rst_wb_we", {31'd0, wb_rdWriteEnable}, 32'd0);
    checkOutput("rst_bus_error", {31'd0, bus_error}, 32'd0);
    checkOutput("rst_misalign", {31'd0, misalign}, 32'd0);
    reset = 1'b0;

    // Non-memory ops back-to-back
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010, 32'h1234 + 32'(i), 5'd5, 1'b1);
      tick();
      checkOutput("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
      checkOutput("alu_wb_data", wb_rdData, 32'h1234 + 32'(i));
      checkOutput("alu_wb_rd", {27'd0, wb_rdAddr}, 32'd5);
      checkOutput("alu_wb_we", {31'd0, wb_rdWriteEnable}, 32'd1);
      checkOutput("alu_stall", {31'd0, stall}, 32'd0);
    end
    applyIdle();
    tick();
    checkOutput("alu_wb_drop", {31'd0, wb_valid}, 32'd0);

    // SB 0xAB @ 0x1003 with two ready-low cycles
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h1003, 32'h0000_00AB, 3'b000, 32'h0, 5'd9, 1'b1);
    tick();
    applyIdle();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.req_ready = 1'b1;
      checkOutput("sb_stall", {31'd0, stall}, 32'd1);
      checkOutput("sb_req_valid", {31'd0, bus.req_valid}, 32'd1);
      checkOutput("sb_req_write", {31'd0, bus.req_write}, 32'd1);
      checkOutput("sb_req_addr", {2'b00, bus.req_addr}, 32'h0000_0400);
      checkOutput("sb_mask", {28'd0, bus.req_byteMask}, 32'b1000);
      checkOutput("sb_wdata", bus.req_wdata, 32'hAB00_0000);
      checkOutput("sb_wb_idle", {31'd0, wb_valid}, 32'd0);
      tick();
    end
    bus.req_ready = 1'b0;
    checkOutput("sb_wb_valid", {31'd0, wb_valid}, 32'd1);
    checkOutput("sb_wb_we", {31'd0, wb_rdWriteEnable}, 32'd0);
    checkOutput("sb_stall_done", {31'd0, stall}, 32'd0);
    checkOutput("sb_req_done", {31'd0, bus.req_valid}, 32'd0);
    tick();
    checkOutput("sb_wb_pulse", {31'd0, wb_valid}, 32'd0);

    // SH and SW lane placement
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h1002, 32'h0000_BEEF, 3'b001, 32'h0, 5'd0, 1'b0);
    tick();
    applyIdle();
    checkOutput("sh_mask", {28'd0, bus.req_byteMask}, 32'b1100);
    checkOutput("sh_wdata", bus.req_wdata, 32'hBEEF_0000);
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h1000, 32'h1357_9BDF, 3'b010, 32'h0, 5'd0, 1'b0);
    tick();
    applyIdle();
    checkOutput("sw_mask", {28'd0, bus.req_byteMask}, 32'b1111);
    checkOutput("sw_wdata", bus.req_wdata, 32'h1357_9BDF);
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    tick();

    // LB @ 0x2002, response three cycles after handshake
    doLoad(3'b000, 32'h2002, 32'h0080_0000, 3, 5'd7);
    checkOutput("lb_wb_valid", {31'd0, wb_valid}, 32'd1);
    checkOutput("lb_wb_data", wb_rdData, 32'hFFFF_FF80);
    checkOutput("lb_wb_we", {31'd0, wb_rdWriteEnable}, 32'd1);
    checkOutput("lb_wb_rd", {27'd0, wb_rdAddr}, 32'd7);
    checkOutput("lb_stall", {31'd0, stall}, 32'd0);
    checkOutput("lb_bus_error", {31'd0, bus_error}, 32'd0);

    doLoad(3'b101, 32'h2002, 32'h8001_FFFF, 1, 5'd8);
    checkOutput("lhu_wb_data", wb_rdData, 32'h0000_8001);
    doLoad(3'b001, 32'h2000, 32'h1234_8765, 2, 5'd9);
    checkOutput("lh_wb_data", wb_rdData, 32'hFFFF_8765);
    doLoad(3'b100, 32'h2001, 32'h0000_F000, 1, 5'd10);
    checkOutput("lbu_wb_data", wb_rdData, 32'h0000_00F0);
    doLoad(3'b010, 32'h2004, 32'hDEAD_BEEF, 1, 5'd11);
    checkOutput("lw_wb_data", wb_rdData, 32'hDEAD_BEEF);

    // Read and write both set behaves as a load
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h2000, 32'hFFFF_FFFF, 3'b010, 32'h0, 5'd1, 1'b1);
    tick();
    applyIdle();
    checkOutput("rw_req_write", {31'd0, bus.req_write}, 32'd0);
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    checkOutput("rw_wait_stall", {31'd0, stall}, 32'd1);
    bus.rsp_valid = 1'b1;
    bus.rsp_rdata = 32'h0BAD_F00D;
    tick();
    bus.rsp_valid = 1'b0;
    checkOutput("rw_wb_data", wb_rdData, 32'h0BAD_F00D);

    // Stray response while idle is ignored
    bus.rsp_valid = 1'b1;
    tick();
    bus.rsp_valid = 1'b0;
    checkOutput("stray_rsp_wb", {31'd0, wb_valid}, 32'd0);

    // Watchdog expiry after four silent WAIT_RSP cycles
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h2008, 32'h0, 3'b010, 32'h0, 5'd12, 1'b1);
    tick();
    applyIdle();
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    tick(); tick(); tick();
    checkOutput("wd_still_wait", {31'd0, stall}, 32'd1);
    checkOutput("wd_no_early_wb", {31'd0, wb_valid}, 32'd0);
    tick();
    checkOutput("wd_wb_valid", {31'd0, wb_valid}, 32'd1);
    checkOutput("wd_bus_error", {31'd0, bus_error}, 32'd1);
    checkOutput("wd_wb_we", {31'd0, wb_rdWriteEnable}, 32'd0);
    checkOutput("wd_stall", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("wd_err_pulse", {31'd0, bus_error}, 32'd0);

    // Response on the fourth WAIT_RSP cycle beats the watchdog
    doLoad(3'b010, 32'h200C, 32'h1122_3344, 4, 5'd13);
    checkOutput("wd_race_valid", {31'd0, wb_valid}, 32'd1);
    checkOutput("wd_race_error", {31'd0, bus_error}, 32'd0);
    checkOutput("wd_race_data", wb_rdData, 32'h1122_3344);
    checkOutput("wd_race_we", {31'd0, wb_rdWriteEnable}, 32'd1);

    // Reset during REQ drops the request
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h2010, 32'h0, 3'b010, 32'h0, 5'd14, 1'b1);
    tick();
    applyIdle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst_req_drop", {31'd0, bus.req_valid}, 32'd0);

    // Reset during WAIT_RSP, late response ignored
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h2010, 32'h0, 3'b010, 32'h0, 5'd14, 1'b1);
    tick();
    applyIdle();
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst_wait_stall", {31'd0, stall}, 32'd0);
    bus.rsp_valid = 1'b1;
    bus.rsp_rdata = 32'hFEED_FACE;
    tick();
    bus.rsp_valid = 1'b0;
    checkOutput("rst_late_rsp_wb", {31'd0, wb_valid}, 32'd0);
    checkOutput("rst_late_rsp_stall", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("rst_late_rsp_wb2", {31'd0, wb_valid}, 32'd0);

    // LW @ 0x3001: trapped with the macro, issued as lane-0 word without it
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h3001, 32'h0, 3'b010, 32'h0, 5'd15, 1'b1);
    tick();
    applyIdle();
`ifdef JZJPCC_MEM_MISALIGN_TRAP_EN
    checkOutput("mis_req_valid", {31'd0, bus.req_valid}, 32'd0);
    checkOutput("mis_wb_valid", {31'd0, wb_valid}, 32'd1);
    checkOutput("mis_flag", {31'd0, misalign}, 32'd1);
    checkOutput("mis_wb_we", {31'd0, wb_rdWriteEnable}, 32'd0);
    checkOutput("mis_stall", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("mis_pulse", {31'd0, misalign}, 32'd0);
`else
    checkOutput("mis_req_valid", {31'd0, bus.req_valid}, 32'd1);
    checkOutput("mis_req_addr", {2'b00, bus.req_addr}, 32'h0000_0C00);
    checkOutput("mis_mask", {28'd0, bus.req_byteMask}, 32'b1111);
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b1;
    bus.rsp_rdata = 32'hCAFE_F00D;
    tick();
    bus.rsp_valid = 1'b0;
    checkOutput("mis_wb_data", wb_rdData, 32'hCAFE_F00D);
    checkOutput("mis_flag", {31'd0, misalign}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
